gpr_wb_sched: RTL and testbench

Write-port scheduler for the general-purpose register file. It shares the register file's single write port between two writeback requesters: the execute/memory result path (EX) and the CSR read-data path (CSR). It zero-initialises x1..x31 after reset or on request, and flags read operands that would return stale data because a write to the same register is in flight. It sits between the writeback stage and the register file write inputs (write enable, write address, write data).

---
 rtl/gpr_wb_sched.sv | 103 ++++++++++
 tb/tb_gpr_wb_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_sched.sv
// Write-port scheduler for the GPR file: arbitrates EX and CSR writebacks onto
// the single register-file write port, zero-fills x1..x31 after reset or on
// request, and flags reads that race an in-flight write.
module gpr_wb_sched #(
    parameter bit INIT_EN = 1'b1,
    parameter bit PRIO0   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_req,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_data,
    input  logic        csr_valid,
    output logic        csr_ready,
    input  logic [4:0]  csr_rd,
    input  logic [31:0] csr_data,
    output logic        gpr_we,
    output logic [4:0]  gpr_rd,
    output logic [31:0] gpr_wdata,
    input  logic [4:0]  rd_ra,
    input  logic [4:0]  rd_rb,
    output logic        fwd_a,
    output logic        fwd_b,
    output logic [31:0] fwd_data,
    output logic        init_done
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic          ptr;

    logic          run;
    logic          open;
    logic          ex_go;
    logic          csr_go;
    logic          contend;

    // Arbitration: ready never looks at the requester's own valid
    assign run       = (state == ST_RUN);
    assign open      = run & ~init_req;
    assign ex_ready  = open & (~csr_valid | ~ptr);
    assign csr_ready = open & (~ex_valid | ptr);
    assign ex_go     = ex_valid & ex_ready;
    assign csr_go    = csr_valid & csr_ready;
    assign contend   = open & ex_valid & csr_valid;

    // Stale-read detection off the registered write command; x0 never stale
    assign fwd_a     = gpr_we & (gpr_rd == rd_ra) & (rd_ra != '0);
    assign fwd_b     = gpr_we & (gpr_rd == rd_rb) & (rd_rb != '0);
    assign fwd_data  = run ? gpr_wdata : '0;
    assign init_done = run;

    // Sequencer: zero-fill walk in INIT, one granted write per cycle in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT_EN ? ST_INIT : ST_RUN;
            cnt       <= AW'(1);
            ptr       <= PRIO0;
            gpr_we    <= 1'b0;
            gpr_rd    <= '0;
            gpr_wdata <= '0;
        end else if (state == ST_INIT) begin
            gpr_we    <= 1'b1;
            gpr_rd    <= cnt;
            gpr_wdata <= '0;
            cnt       <= cnt + AW'(1);
            if (cnt == '1) begin
                state <= ST_RUN;
            end
        end else begin
            if (init_req) begin
                state  <= ST_INIT;
                cnt    <= AW'(1);
                gpr_we <= 1'b0;
            end else if (ex_go) begin
                gpr_we    <= (ex_rd != '0);
                gpr_rd    <= ex_rd;
                gpr_wdata <= DW'(ex_data);
            end else if (csr_go) begin
                gpr_we    <= (csr_rd != '0);
                gpr_rd    <= csr_rd;
                gpr_wdata <= DW'(csr_data);
            end else begin
                gpr_we <= 1'b0;
            end
            // Contended grant hands priority to the side that lost
            if (contend) begin
                ptr <= ~ptr;
            end
        end
    end

endmodule

// File: tb/tb_gpr_wb_sched.sv
// Randomized bench for gpr_wb_sched: requesters are queues of pending
// writebacks, the reference tracks the zero-fill as a list of addresses still
// to be cleared and the write port as the last committed transaction.
module tb_gpr_wb_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_req;
    logic        ex_valid, ex_ready, csr_valid, csr_ready;
    logic [4:0]  ex_rd, csr_rd, rd_ra, rd_rb, gpr_rd;
    logic [31:0] ex_data, csr_data, gpr_wdata, fwd_data;
    logic        gpr_we, fwd_a, fwd_b, init_done;

    gpr_wb_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_req  (init_req),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_rd     (ex_rd),
        .ex_data   (ex_data),
        .csr_valid (csr_valid),
        .csr_ready (csr_ready),
        .csr_rd    (csr_rd),
        .csr_data  (csr_data),
        .gpr_we    (gpr_we),
        .gpr_rd    (gpr_rd),
        .gpr_wdata (gpr_wdata),
        .rd_ra     (rd_ra),
        .rd_rb     (rd_rb),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .fwd_data  (fwd_data),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } req_t;

    int n_vec = 0;
    int n_err = 0;

    // requester side
    req_t ex_q[$];
    req_t cs_q[$];
    bit   ex_act = 1'b0;
    bit   cs_act = 1'b0;
    bit   rnd_valid = 1'b0;
    bit   ireq_k = 1'b0;
    logic [4:0] ra_k = '0;
    logic [4:0] rb_k = '0;

    // reference model
    bit          m_run;
    int          init_q[$];
    bit          m_ptr;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wdata;

    // observed write log
    bit         logging = 1'b0;
    logic [4:0] wlog[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic fill_init();
        init_q.delete();
        for (int a = 1; a < 32; a++) init_q.push_back(a);
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        fill_init();
        m_ptr   = 1'b0;
        m_we    = 1'b0;
        m_rd    = '0;
        m_wdata = '0;
        ex_act  = 1'b0;
        cs_act  = 1'b0;
    endtask

    task automatic push_ex(input logic [4:0] rd, input logic [31:0] d);
        req_t r;
        r.rd = rd; r.data = d;
        ex_q.push_back(r);
    endtask

    task automatic push_cs(input logic [4:0] rd, input logic [31:0] d);
        req_t r;
        r.rd = rd; r.data = d;
        cs_q.push_back(r);
    endtask

    // One clock: drive at negedge, check after settling, advance model at posedge
    task automatic cycle();
        bit   exr, csr, go_e, go_c;
        req_t r;
        @(negedge clk);
        if (!ex_act && ex_q.size() > 0 && (!rnd_valid || $urandom_range(0, 1) == 1)) ex_act = 1'b1;
        if (!cs_act && cs_q.size() > 0 && (!rnd_valid || $urandom_range(0, 1) == 1)) cs_act = 1'b1;
        ex_valid  = ex_act;
        ex_rd     = ex_act ? ex_q[0].rd : 5'($urandom);
        ex_data   = ex_act ? ex_q[0].data : $urandom;
        csr_valid = cs_act;
        csr_rd    = cs_act ? cs_q[0].rd : 5'($urandom);
        csr_data  = cs_act ? cs_q[0].data : $urandom;
        init_req  = ireq_k;
        rd_ra     = ra_k;
        rd_rb     = rb_k;
        #1;
        exr = m_run && !ireq_k && (!cs_act || !m_ptr);
        csr = m_run && !ireq_k && (!ex_act || m_ptr);
        check("ex_ready",  32'(ex_ready),  32'(exr));
        check("csr_ready", 32'(csr_ready), 32'(csr));
        check("gpr_we",    32'(gpr_we),    32'(m_we));
        check("gpr_rd",    32'(gpr_rd),    32'(m_rd));
        check("gpr_wdata", gpr_wdata,      m_wdata);
        check("fwd_a",     32'(fwd_a),     32'(m_we && m_rd == ra_k && ra_k != 0));
        check("fwd_b",     32'(fwd_b),     32'(m_we && m_rd == rb_k && rb_k != 0));
        check("fwd_data",  fwd_data,       m_run ? m_wdata : 32'h0);
        check("init_done", 32'(init_done), 32'(m_run));
        if (logging && gpr_we) wlog.push_back(gpr_rd);
        @(posedge clk);
        if (!m_run) begin
            m_we    = 1'b1;
            m_rd    = 5'(init_q.pop_front());
            m_wdata = '0;
            if (init_q.size() == 0) m_run = 1'b1;
        end else if (ireq_k) begin
            m_run = 1'b0;
            fill_init();
            m_we  = 1'b0;
        end else begin
            go_e = ex_act && exr;
            go_c = cs_act && csr;
            if (go_e) begin
                r = ex_q.pop_front();
                ex_act = 1'b0;
            end else if (go_c) begin
                r = cs_q.pop_front();
                cs_act = 1'b0;
            end
            if (go_e || go_c) begin
                m_we    = (r.rd != 0);
                m_rd    = r.rd;
                m_wdata = r.data;
            end else begin
                m_we = 1'b0;
            end
            if (ex_act_prev_both(go_e, go_c)) m_ptr = ~m_ptr;
        end
    endtask

    // Both requesters were valid this cycle exactly when one won and the other
    // is still waiting afterwards.
    function automatic bit ex_act_prev_both(input bit go_e, input bit go_c);
        return (go_e && cs_act) || (go_c && ex_act);
    endfunction

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((ex_q.size() > 0 || cs_q.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) check("idle_timeout", 32'd1, 32'd0);
        cycle();
    endtask

    task automatic run_until_run(input int budget);
        int n = 0;
        while (!m_run && n < budget) begin
            cycle();
            n++;
        end
        if (!m_run) check("init_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic [4:0] exp_order [8];
        rst_n = 1'b0;
        init_req = 1'b0; ex_valid = 1'b0; csr_valid = 1'b0;
        ex_rd = '0; csr_rd = '0; ex_data = '0; csr_data = '0;
        rd_ra = '0; rd_rb = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check("rst_gpr_we", 32'(gpr_we), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        rst_n = 1'b1;

        // zero-fill after reset, then first EX write with no gap
        push_ex(5'd5, 32'hDEADBEEF);
        run_until_run(40);
        run_until_idle(10);

        // stale-read flag on the cycle the write is on the port
        ra_k = 5'd7; rb_k = 5'd8;
        push_ex(5'd7, 32'hA5A5A5A5);
        run_until_idle(10);
        cycle();

        // write to x0 handshakes but is dropped; no flag on x0
        ra_k = 5'd0; rb_k = 5'd0;
        push_ex(5'd0, 32'h00001234);
        run_until_idle(10);

        // sustained contention alternates starting with EX
        for (int i = 0; i < 4; i++) begin
            push_ex(5'(1 + i), $urandom);
            push_cs(5'(9 + i), $urandom);
        end
        wlog.delete();
        logging = 1'b1;
        run_until_idle(20);
        logging = 1'b0;
        exp_order = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};
        check("contend_count", 32'(wlog.size()), 32'd8);
        for (int i = 0; i < 8 && i < wlog.size(); i++) check("contend_order", 32'(wlog[i]), 32'(exp_order[i]));

        // init_req with EX waiting: EX blocked, zero-fill, then EX granted
        push_ex(5'd20, 32'hCAFEF00D);
        ireq_k = 1'b1;
        cycle();
        ireq_k = 1'b0;
        run_until_idle(60);

        // randomized traffic with occasional re-init
        rnd_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) push_ex(5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 3) == 0) push_cs(5'($urandom_range(0, 7)), $urandom);
            ra_k   = 5'($urandom_range(0, 7));
            rb_k   = 5'($urandom_range(0, 7));
            ireq_k = ($urandom_range(0, 59) == 0);
            cycle();
            ireq_k = 1'b0;
        end
        run_until_idle(200);
        rnd_valid = 1'b0;

        // asynchronous reset in the middle of the zero-fill
        ireq_k = 1'b1;
        cycle();
        ireq_k = 1'b0;
        while (!m_run && init_q.size() > 0 && init_q[0] != 17) cycle();
        check("pre_rst_we", 32'(gpr_we), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_we", 32'(gpr_we), 32'd0);
        check("async_rd", 32'(gpr_rd), 32'd0);
        check("async_done", 32'(init_done), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_until_run(40);
        push_ex(5'd3, 32'h0BADF00D);
        run_until_idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
